// File: rtl/axis_ascon_verified_release.sv
// axis_ascon_verified_release: holds decrypted plaintext until its tag
// check word arrives; releases the beats on a match, discards otherwise.
module axis_ascon_verified_release #(
    parameter int aw           = 4,
    parameter bit keep_support = 1'b1,
    parameter int cnt_w        = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [127:0]     s_tdata,
    input  logic [15:0]      s_tkeep,
    input  logic             s_tag_tvalid,
    output logic             s_tag_tready,
    input  logic [127:0]     s_tag_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [127:0]     m_tdata,
    output logic [15:0]      m_tkeep,
    output logic             m_status_tvalid,
    input  logic             m_status_tready,
    output logic [1:0]       m_status_tdata,
    output logic [cnt_w-1:0] err_count
);
    localparam int DEPTH = 1 << aw;
    localparam logic [aw:0]      CNT_ONE = 1;
    localparam logic [aw-1:0]    RD_ONE  = 1;
    localparam logic [cnt_w-1:0] ERR_ONE = 1;

    typedef enum logic [1:0] {COLLECT, WAIT_TAG, RELEASE, STATUS} state_e;

    state_e           state_q, state_d;
    logic [aw:0]      cnt_q, cnt_d;
    logic [aw-1:0]    rd_q, rd_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       status_q, status_d;
    logic [cnt_w-1:0] err_q, err_d;
    logic             mv_q, mv_d;
    logic             ml_q, ml_d;
    logic [127:0]     md_q, md_d;
    logic [15:0]      mk_q, mk_d;
    logic [144:0]     mem [DEPTH];
    logic [144:0]     rd_word;
    logic             wr_en;
    logic [15:0]      keep_in;

    assign keep_in = keep_support ? s_tkeep : 16'hFFFF;
    assign rd_word = mem[rd_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        ovf_d    = ovf_q;
        status_d = status_q;
        err_d    = err_q;
        mv_d     = mv_q;
        ml_d     = ml_q;
        md_d     = md_q;
        mk_d     = mk_q;
        wr_en    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (s_tvalid) begin
                    // cnt_q[aw] set means the buffer holds DEPTH beats
                    if (cnt_q[aw]) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (s_tlast) state_d = WAIT_TAG;
                end
            end
            WAIT_TAG: begin
                if (s_tag_tvalid) begin
                    if (ovf_q) begin
                        status_d = 2'd2;
                        state_d  = STATUS;
                    end else if (s_tag_tdata != '0) begin
                        status_d = 2'd1;
                        state_d  = STATUS;
                    end else begin
                        state_d = RELEASE;
                        mv_d    = 1'b1;
                        {ml_d, md_d, mk_d} = rd_word;
                        rd_d    = rd_q + RD_ONE;
                    end
                end
            end
            RELEASE: begin
                if (mv_q && m_tready) begin
                    if (ml_q) begin
                        mv_d     = 1'b0;
                        ml_d     = 1'b0;
                        status_d = 2'd0;
                        state_d  = STATUS;
                    end else begin
                        {ml_d, md_d, mk_d} = rd_word;
                        rd_d = rd_q + RD_ONE;
                    end
                end
            end
            STATUS: begin
                if (m_status_tready) begin
                    if (status_q != 2'd0 && err_q != '1) err_d = err_q + ERR_ONE;
                    cnt_d   = '0;
                    rd_d    = '0;
                    ovf_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            rd_q     <= '0;
            ovf_q    <= 1'b0;
            status_q <= 2'd0;
            err_q    <= '0;
            mv_q     <= 1'b0;
            ml_q     <= 1'b0;
            md_q     <= '0;
            mk_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
            status_q <= status_d;
            err_q    <= err_d;
            mv_q     <= mv_d;
            ml_q     <= ml_d;
            md_q     <= md_d;
            mk_q     <= mk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt_q[aw-1:0]] <= {s_tlast, s_tdata, keep_in};
    end

    assign s_tready        = (state_q == COLLECT);
    assign s_tag_tready    = (state_q == WAIT_TAG);
    assign m_tvalid        = mv_q;
    assign m_tlast         = ml_q;
    assign m_tdata         = md_q;
    assign m_tkeep         = keep_support ? mk_q : 16'hFFFF;
    assign m_status_tvalid = (state_q == STATUS);
    assign m_status_tdata  = status_q;
    assign err_count       = err_q;
endmodule

// File: tb/tb_axis_ascon_verified_release.sv
// Bench for axis_ascon_verified_release: random messages checked against
// a queue-based model of tag-gated release and status reporting.
module tb_axis_ascon_verified_release;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic           s_tlast = 1'b0;
    logic [127:0]   s_tdata = '0;
    logic [15:0]    s_tkeep = '0;
    logic           s_tag_tvalid = 1'b0;
    logic           s_tag_tready;
    logic [127:0]   s_tag_tdata = '0;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic           m_tlast;
    logic [127:0]   m_tdata;
    logic [15:0]    m_tkeep;
    logic           m_status_tvalid;
    logic           m_status_tready = 1'b0;
    logic [1:0]     m_status_tdata;
    logic [CW-1:0]  err_count;

    axis_ascon_verified_release #(.aw(AW), .keep_support(1'b1), .cnt_w(CW)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready),
        .s_tag_tdata(s_tag_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_status_tvalid(m_status_tvalid), .m_status_tready(m_status_tready),
        .m_status_tdata(m_status_tdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [127:0] dq[$];
    logic [15:0]  kq[$];
    int           st_exp;
    logic [CW-1:0] err_exp = '0;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic gen(input int n);
        dq.delete();
        kq.delete();
        for (int i = 0; i < n; i++) begin
            dq.push_back(rnd128());
            kq.push_back(16'($urandom()));
        end
    endtask

    task automatic send_msg(input logic [127:0] tag);
        int cyc;
        int stalls;
        bit saw;
        st_exp = (dq.size() > DEPTH) ? 2 : ((tag != '0) ? 1 : 0);
        stalls = 0;
        saw = 0;
        @(negedge clk);
        for (int i = 0; i < dq.size(); i++) begin
            s_tvalid = 1'b1;
            s_tdata  = dq[i];
            s_tkeep  = kq[i];
            s_tlast  = (i == dq.size() - 1);
            cyc = 0;
            while (!s_tready && cyc < 20) begin
                stalls++;
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
            if (m_tvalid) saw = 1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tests++;
        if (stalls !== 0) begin
            fails++;
            $display("FAIL s_tready_stall: got %0d stall cycles want 0", stalls);
        end
        tests++;
        if (saw) begin
            fails++;
            $display("FAIL early_m_tvalid: got 1 during collect want 0");
        end
        s_tag_tvalid = 1'b1;
        s_tag_tdata  = tag;
        cyc = 0;
        while (!s_tag_tready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (s_tag_tready !== 1'b1) begin
            fails++;
            $display("FAIL tag_ready_timeout: got %b want 1", s_tag_tready);
        end
        @(negedge clk);
        s_tag_tvalid = 1'b0;
        tests++;
        if (m_tvalid !== (st_exp == 0) || m_status_tvalid !== (st_exp != 0)) begin
            fails++;
            $display("FAIL post_tag: got tvalid=%b status_tvalid=%b want %b/%b",
                     m_tvalid, m_status_tvalid, st_exp == 0, st_exp != 0);
        end
    endtask

    task automatic finish_msg(input int mode, input int sdly);
        logic [144:0] got[$];
        logic [144:0] prev;
        logic [144:0] cur;
        logic [144:0] exp;
        bit pv;
        bit rdy;
        int cyc;
        int n;
        pv = 0;
        prev = '0;
        cyc = 0;
        while (!m_status_tvalid && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : ((mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1)));
            m_tready = rdy;
            cur = {m_tlast, m_tdata, m_tkeep};
            if (pv) begin
                tests++;
                if (cur !== prev || m_tvalid !== 1'b1) begin
                    fails++;
                    $display("FAIL hold_stable: got %h want %h", cur, prev);
                end
            end
            tests++;
            if (s_tready !== 1'b0) begin
                fails++;
                $display("FAIL s_tready_release: got %b want 0", s_tready);
            end
            if (m_tvalid && rdy) got.push_back(cur);
            pv = m_tvalid && !rdy;
            prev = cur;
            @(negedge clk);
            cyc++;
        end
        m_tready = 1'b0;
        tests++;
        if (m_status_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL status_timeout: got %b want 1", m_status_tvalid);
        end
        n = (st_exp == 0) ? dq.size() : 0;
        tests++;
        if (got.size() != n) begin
            fails++;
            $display("FAIL beat_count: got %0d want %0d", got.size(), n);
        end
        for (int i = 0; i < got.size() && i < n; i++) begin
            exp = {(i == n - 1), dq[i], kq[i]};
            tests++;
            if (got[i] !== exp) begin
                fails++;
                $display("FAIL beat_%0d: got %h want %h", i, got[i], exp);
            end
        end
        for (int d = 0; d < sdly; d++) begin
            tests++;
            if (m_status_tvalid !== 1'b1 || m_status_tdata !== 2'(st_exp) || s_tready !== 1'b0) begin
                fails++;
                $display("FAIL status_wait: got v=%b d=%0d rdy=%b want 1/%0d/0",
                         m_status_tvalid, m_status_tdata, s_tready, st_exp);
            end
            @(negedge clk);
        end
        m_status_tready = 1'b1;
        tests++;
        if (m_status_tdata !== 2'(st_exp)) begin
            fails++;
            $display("FAIL status: got %0d want %0d", m_status_tdata, st_exp);
        end
        @(negedge clk);
        m_status_tready = 1'b0;
        if (st_exp != 0 && err_exp != '1) err_exp = err_exp + 1'b1;
        tests++;
        if (m_status_tvalid !== 1'b0 || s_tready !== 1'b1 || err_count !== err_exp) begin
            fails++;
            $display("FAIL after_status: got v=%b rdy=%b err=%0d want 0/1/%0d",
                     m_status_tvalid, s_tready, err_count, err_exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if (s_tready !== 1'b1 || s_tag_tready !== 1'b0 || m_tvalid !== 1'b0 ||
            m_tlast !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 ||
            m_status_tvalid !== 1'b0 || m_status_tdata !== 2'd0 || err_count !== '0) begin
            fails++;
            $display("FAIL %s: got rdy=%b trdy=%b v=%b l=%b d=%h k=%h sv=%b sd=%0d e=%0d want 1 0 0 0 0 0 0 0 0",
                     tag, s_tready, s_tag_tready, m_tvalid, m_tlast, m_tdata, m_tkeep,
                     m_status_tvalid, m_status_tdata, err_count);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_reset_vals("reset");
    endtask

    task automatic test_pass3();
        gen(3);
        kq[0] = 16'hFFFF;
        kq[1] = 16'hFFFF;
        kq[2] = 16'h00FF;
        send_msg('0);
        finish_msg(0, 1);
    endtask

    task automatic test_mismatch2();
        gen(2);
        send_msg(128'h1);
        finish_msg(0, 2);
    endtask

    task automatic test_overflow6();
        gen(6);
        send_msg('0);
        finish_msg(0, 1);
    endtask

    task automatic test_full4();
        gen(DEPTH);
        send_msg('0);
        finish_msg(0, 0);
    endtask

    task automatic test_back_to_back();
        gen(4);
        send_msg('0);
        finish_msg(1, 5);
    endtask

    task automatic test_random();
        logic [127:0] tag;
        for (int m = 0; m < 12; m++) begin
            gen($urandom_range(1, 6));
            tag = ($urandom_range(0, 2) == 0) ? rnd128() : '0;
            send_msg(tag);
            finish_msg(2, $urandom_range(0, 3));
        end
    endtask

    task automatic test_mid_reset();
        gen(3);
        send_msg('0);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        err_exp = '0;
        gen(1);
        send_msg('0);
        finish_msg(0, 1);
    endtask

    initial begin
        test_reset();
        test_pass3();
        test_mismatch2();
        test_overflow6();
        test_full4();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
